// File: rtl/poly_byte_encode_pkg.sv
// Shared constants, pair layout and byte-packing helper for the ByteEncode_12 read-out path.
package poly_byte_encode_pkg;

    localparam int N_COEFF = 256;
    localparam int N_PAIRS = N_COEFF / 2;
    localparam int N_BYTES = N_COEFF * 12 / 8;
    localparam logic [11:0] Q = 12'd3329;

    typedef struct packed {
        logic [11:0] c1;
        logic [11:0] c0;
    } pair_t;

    // With c1 above c0 the three output bytes are simply consecutive 8-bit slices.
    function automatic logic [7:0] pack_byte(input pair_t p, input logic [1:0] idx);
        case (idx)
            2'd0:    return p[7:0];
            2'd1:    return p[15:8];
            default: return p[23:16];
        endcase
    endfunction

endpackage

// File: rtl/poly_byte_encode_if.sv
// Byte stream carrying the encoded polynomial from the encoder to its sink.
interface poly_byte_encode_if;
    logic [7:0] tdata;
    logic       tvalid;
    logic       tready;
    logic       tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/poly_byte_encode_ram.sv
// 256 x 12 dual-port coefficient RAM, one-cycle registered read on both ports, no reset.
module poly_byte_encode_ram (
    input  logic        clk,
    input  logic        we_a,
    input  logic [7:0]  addr_a,
    input  logic [11:0] din_a,
    output logic [11:0] dout_a,
    input  logic        we_b,
    input  logic [7:0]  addr_b,
    input  logic [11:0] din_b,
    output logic [11:0] dout_b
);
    logic [11:0] mem [256];

    always_ff @(posedge clk) begin
        if (we_a) mem[addr_a] <= din_a;
        if (we_b) mem[addr_b] <= din_b;
        dout_a <= mem[addr_a];
        dout_b <= mem[addr_b];
    end
endmodule

// File: rtl/poly_byte_encode.sv
// Streams one polynomial out of the coefficient RAM as 384 ByteEncode_12 bytes.
//   state  | meaning
//   S_IDLE | waiting for start; external RAM writes accepted
//   S_RUN  | fetching pairs and emitting bytes
//   S_DONE | one-cycle done pulse after the last byte
module poly_byte_encode
    import poly_byte_encode_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        done,
    output logic        busy,
    output logic        err,
    input  logic        p_we,
    input  logic [7:0]  p_addr,
    input  logic [11:0] p_din,
    output logic [11:0] p_dout,
    poly_byte_encode_if.master m
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]  state;
    logic [7:0]  pcnt;
    logic        ph, rv, rph;
    logic [11:0] lo_c0, dout_b;
    logic [7:0]  addr_b;
    pair_t       cur_q, next_q, pair_word;
    logic        cur_v, next_v, n_next_v;
    logic [1:0]  bidx;
    logic [8:0]  bcnt;
    logic        hs, last_b, pair_done, to_cur, to_next, issue, we_a;

    assign hs        = cur_v & m.tready;
    assign last_b    = hs & (bidx == 2'd2);
    assign pair_done = rv & rph;
    assign pair_word = {dout_b, lo_c0};
    // A finished pair bypasses NEXT when CUR is empty or emptying on this edge.
    assign to_cur    = pair_done & (~cur_v | last_b);
    assign to_next   = pair_done & ~to_cur;

    always_comb begin
        n_next_v = next_v;
        if (last_b)  n_next_v = 1'b0;
        if (to_next) n_next_v = 1'b1;
    end

    // A new pair is only started when NEXT will be free, so at most one pair is in flight.
    assign issue  = (state == S_RUN) & (pcnt < 8'(N_PAIRS)) & (ph | ~n_next_v);
    assign addr_b = {pcnt[6:0], ph};
    assign we_a   = p_we & (state == S_IDLE);

    poly_byte_encode_ram u_ram (
        .clk    (clk),
        .we_a   (we_a),
        .addr_a (p_addr),
        .din_a  (p_din),
        .dout_a (p_dout),
        .we_b   (1'b0),
        .addr_b (addr_b),
        .din_b  (12'd0),
        .dout_b (dout_b)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            pcnt   <= 8'd0;
            ph     <= 1'b0;
            rv     <= 1'b0;
            rph    <= 1'b0;
            lo_c0  <= 12'd0;
            cur_q  <= '0;
            next_q <= '0;
            cur_v  <= 1'b0;
            next_v <= 1'b0;
            bidx   <= 2'd0;
            bcnt   <= 9'd0;
            err    <= 1'b0;
        end else begin
            rv  <= issue;
            rph <= ph;
            if (issue) begin
                ph <= ~ph;
                if (ph) pcnt <= pcnt + 8'd1;
            end
            if (rv && !rph) lo_c0 <= dout_b;
            if (rv && (dout_b >= Q)) err <= 1'b1;

            if (hs) begin
                bidx <= (bidx == 2'd2) ? 2'd0 : bidx + 2'd1;
                bcnt <= bcnt + 9'd1;
            end
            if (to_cur) begin
                cur_q <= pair_word;
                cur_v <= 1'b1;
            end else if (last_b) begin
                cur_q <= next_q;
                cur_v <= next_v;
            end
            if (to_next) next_q <= pair_word;
            next_v <= n_next_v;

            unique case (state)
                S_IDLE: if (start) begin
                    state <= S_RUN;
                    err   <= 1'b0;
                    pcnt  <= 8'd0;
                    ph    <= 1'b0;
                    bidx  <= 2'd0;
                    bcnt  <= 9'd0;
                end
                S_RUN:  if (hs && (bcnt == 9'(N_BYTES - 1))) state <= S_DONE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign m.tvalid = cur_v;
    assign m.tlast  = cur_v & (bcnt == 9'(N_BYTES - 1));
    assign m.tdata  = cur_v ? pack_byte(cur_q, bidx) : 8'd0;
    assign busy     = (state != S_IDLE);
    assign done     = (state == S_DONE);
endmodule

// File: tb/tb_poly_byte_encode.sv
// Randomised self-checking bench for poly_byte_encode against a coefficient-level byte model.
module tb_poly_byte_encode;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        p_we = 1'b0;
    logic [7:0]  p_addr = 8'd0;
    logic [11:0] p_din = 12'd0;
    logic        done, busy, err;
    logic [11:0] p_dout;

    poly_byte_encode_if m_if ();

    poly_byte_encode dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .done   (done),
        .busy   (busy),
        .err    (err),
        .p_we   (p_we),
        .p_addr (p_addr),
        .p_din  (p_din),
        .p_dout (p_dout),
        .m      (m_if)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int ref_c [256];
    logic [7:0] got [$];
    logic       got_err [$];
    int done_cnt, done_cyc, first_valid, stall_bad, last_bad, gaps, err_t0, poke_bad;

    function automatic logic [7:0] exp_byte(input int j);
        int c0, c1, r;
        c0 = ref_c[2 * (j / 3)];
        c1 = ref_c[2 * (j / 3) + 1];
        r  = j % 3;
        if (r == 0) return 8'(c0 % 256);
        if (r == 1) return 8'((c1 % 16) * 16 + c0 / 256);
        return 8'(c1 / 16);
    endfunction

    function automatic int stream_errs();
        int e;
        e = (got.size() == 384) ? 0 : 1;
        for (int j = 0; j < 384 && j < got.size(); j++)
            if (got[j] !== exp_byte(j)) e++;
        return e;
    endfunction

    task automatic fill_random(input int maxv);
        for (int i = 0; i < 256; i++) ref_c[i] = int'($urandom_range(0, maxv));
    endtask

    task automatic load_ram();
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            p_we = 1'b1; p_addr = 8'(i); p_din = 12'(ref_c[i]);
        end
        @(negedge clk);
        p_we = 1'b0;
    endtask

    task automatic collect(input int duty, input int budget, input int stop_at, input int poke_at);
        logic prev_stall;
        logic [7:0] prev_data;
        got.delete(); got_err.delete();
        done_cnt = 0; done_cyc = -1; first_valid = -1; stall_bad = 0; last_bad = 0; gaps = 0; poke_bad = 0;
        prev_stall = 1'b0; prev_data = 8'd0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        err_t0 = int'(err);
        for (int t = 0; t < budget; t++) begin
            if (t > 0) @(negedge clk);
            if (t == poke_at) begin
                start = 1'b1; p_we = 1'b1; p_addr = 8'd5; p_din = 12'(ref_c[5]) ^ 12'hfff;
                if (!busy) poke_bad++;
            end else if (t == poke_at + 1) begin
                start = 1'b0; p_we = 1'b0;
            end
            if (m_if.tvalid && first_valid < 0) first_valid = t;
            if (done) begin done_cnt++; done_cyc = t; end
            if (prev_stall && (!m_if.tvalid || m_if.tdata !== prev_data)) stall_bad++;
            if (m_if.tvalid && (m_if.tlast !== (got.size() == 383))) last_bad++;
            if (!m_if.tvalid && got.size() > 0 && got.size() < 384) gaps++;
            if (stop_at >= 0 && got.size() == stop_at) break;
            m_if.tready = (int'($urandom_range(0, 99)) < duty);
            if (m_if.tvalid && m_if.tready) begin
                got.push_back(m_if.tdata);
                got_err.push_back(err);
            end
            prev_stall = m_if.tvalid && !m_if.tready;
            prev_data  = m_if.tdata;
            if (done_cnt > 0 && t >= done_cyc + 3) break;
        end
        m_if.tready = 1'b0;
    endtask

    task automatic test_reset();
        m_if.tready = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (done !== 1'b0)        begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (busy !== 1'b0)        begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (err !== 1'b0)         begin n_bad++; $display("FAIL reset_err: got %b want 0", err); end
        n_cmp++; if (m_if.tvalid !== 1'b0) begin n_bad++; $display("FAIL reset_tvalid: got %b want 0", m_if.tvalid); end
        n_cmp++; if (m_if.tlast !== 1'b0)  begin n_bad++; $display("FAIL reset_tlast: got %b want 0", m_if.tlast); end
        n_cmp++; if (m_if.tdata !== 8'd0)  begin n_bad++; $display("FAIL reset_tdata: got %h want 00", m_if.tdata); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_pack();
        fill_random(3328);
        ref_c[0] = 'h123; ref_c[1] = 'hABC;
        load_ram();
        collect(100, 2000, -1, -1);
        n_cmp++; if (got.size() < 3 || got[0] !== 8'h23 || got[1] !== 8'hC1 || got[2] !== 8'hAB) begin
            n_bad++; $display("FAIL pack_bytes: got %0d bytes first %h %h %h want 23 C1 AB",
                              got.size(), got.size() > 0 ? got[0] : 8'hxx, got.size() > 1 ? got[1] : 8'hxx,
                              got.size() > 2 ? got[2] : 8'hxx);
        end
        n_cmp++; if (stream_errs() !== 0) begin n_bad++; $display("FAIL pack_stream: %0d bad, got %0d bytes want 384 matching", stream_errs(), got.size()); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL pack_err: got %b want 0", err); end
    endtask

    task automatic test_ramp();
        for (int i = 0; i < 256; i++) ref_c[i] = i;
        load_ram();
        collect(100, 2000, -1, -1);
        n_cmp++; if (first_valid !== 3)  begin n_bad++; $display("FAIL ramp_latency: tvalid first at %0d want 3", first_valid); end
        n_cmp++; if (stream_errs() !== 0) begin n_bad++; $display("FAIL ramp_stream: %0d bad, got %0d bytes want 384 matching", stream_errs(), got.size()); end
        n_cmp++; if (got.size() < 3 || got[0] !== 8'h00 || got[1] !== 8'h10 || got[2] !== 8'h00) begin
            n_bad++; $display("FAIL ramp_first3: got %0d bytes want 00 10 00", got.size());
        end
        n_cmp++; if (gaps !== 0)     begin n_bad++; $display("FAIL ramp_contiguous: %0d gaps want 0", gaps); end
        n_cmp++; if (last_bad !== 0) begin n_bad++; $display("FAIL ramp_tlast: %0d bad tlast cycles want 0", last_bad); end
        n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL ramp_done_count: got %0d want 1", done_cnt); end
        n_cmp++; if (done_cyc !== 387) begin n_bad++; $display("FAIL ramp_done_time: got %0d want 387", done_cyc); end
        n_cmp++; if (err !== 1'b0)   begin n_bad++; $display("FAIL ramp_err: got %b want 0", err); end
        n_cmp++; if (busy !== 1'b0)  begin n_bad++; $display("FAIL ramp_idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_backpressure();
        fill_random(3328);
        load_ram();
        collect(30, 6000, -1, -1);
        n_cmp++; if (stream_errs() !== 0) begin n_bad++; $display("FAIL bp_stream: %0d bad, got %0d bytes want 384 matching", stream_errs(), got.size()); end
        n_cmp++; if (stall_bad !== 0) begin n_bad++; $display("FAIL bp_stable: %0d unstable stalls want 0", stall_bad); end
        n_cmp++; if (last_bad !== 0)  begin n_bad++; $display("FAIL bp_tlast: %0d bad tlast cycles want 0", last_bad); end
        n_cmp++; if (done_cnt !== 1)  begin n_bad++; $display("FAIL bp_done_count: got %0d want 1", done_cnt); end
        n_cmp++; if (err !== 1'b0)    begin n_bad++; $display("FAIL bp_err: got %b want 0", err); end
    endtask

    task automatic test_canonical();
        logic e_lo, e_hi;
        for (int i = 0; i < 256; i++) ref_c[i] = 0;
        ref_c[77] = 3329;
        load_ram();
        collect(100, 2000, -1, -1);
        n_cmp++; if (got.size() < 117 || got[114] !== 8'h00 || got[115] !== 8'h10 || got[116] !== 8'hD0) begin
            n_bad++; $display("FAIL canon_bytes: got %0d bytes want 114..116 = 00 10 D0", got.size());
        end
        e_lo = (got_err.size() > 100) ? got_err[100] : 1'bx;
        e_hi = (got_err.size() > 114) ? got_err[114] : 1'bx;
        n_cmp++; if (e_lo !== 1'b0) begin n_bad++; $display("FAIL canon_err_before: got %b want 0", e_lo); end
        n_cmp++; if (e_hi !== 1'b1) begin n_bad++; $display("FAIL canon_err_after: got %b want 1", e_hi); end
        n_cmp++; if (err !== 1'b1)  begin n_bad++; $display("FAIL canon_err_sticky: got %b want 1", err); end
        ref_c[77] = 0; ref_c[200] = 4095;
        load_ram();
        collect(100, 2000, -1, -1);
        e_lo = (got_err.size() > 250) ? got_err[250] : 1'bx;
        n_cmp++; if (err_t0 !== 0)  begin n_bad++; $display("FAIL canon_err_clear: got %0d want 0", err_t0); end
        n_cmp++; if (e_lo !== 1'b0) begin n_bad++; $display("FAIL canon_err_mid: got %b want 0", e_lo); end
        n_cmp++; if (stream_errs() !== 0) begin n_bad++; $display("FAIL canon_stream: %0d bad, got %0d bytes want 384 matching", stream_errs(), got.size()); end
        n_cmp++; if (err !== 1'b1)  begin n_bad++; $display("FAIL canon_err_4095: got %b want 1", err); end
    endtask

    task automatic test_control();
        fill_random(3328);
        load_ram();
        collect(100, 2000, -1, 50);
        n_cmp++; if (poke_bad !== 0)  begin n_bad++; $display("FAIL ctl_busy: busy low at poke, %0d want 0", poke_bad); end
        n_cmp++; if (stream_errs() !== 0) begin n_bad++; $display("FAIL ctl_stream: %0d bad, got %0d bytes want 384 matching", stream_errs(), got.size()); end
        n_cmp++; if (done_cyc !== 387) begin n_bad++; $display("FAIL ctl_no_restart: done at %0d want 387", done_cyc); end
        @(negedge clk); p_addr = 8'd5;
        @(negedge clk);
        n_cmp++; if (p_dout !== 12'(ref_c[5])) begin n_bad++; $display("FAIL ctl_ram_kept: got %h want %h", p_dout, 12'(ref_c[5])); end
    endtask

    task automatic test_reset_midstream();
        fill_random(3328);
        ref_c[10] = 4000;
        load_ram();
        collect(100, 2000, 200, -1);
        n_cmp++; if (err !== 1'b1 || got.size() !== 200) begin
            n_bad++; $display("FAIL mid_pre: err %b bytes %0d want 1 and 200", err, got.size());
        end
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++; if ({m_if.tvalid, m_if.tlast, m_if.tdata, busy, done, err} !== 13'd0) begin
            n_bad++; $display("FAIL mid_reset_outputs: tvalid %b tlast %b tdata %h busy %b done %b err %b want all 0",
                              m_if.tvalid, m_if.tlast, m_if.tdata, busy, done, err);
        end
        rst_n = 1'b1;
        collect(100, 2000, -1, -1);
        n_cmp++; if (stream_errs() !== 0) begin n_bad++; $display("FAIL mid_restream: %0d bad, got %0d bytes want 384 matching", stream_errs(), got.size()); end
        n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL mid_done_count: got %0d want 1", done_cnt); end
    endtask

    initial begin
        m_if.tready = 1'b0;
        test_reset();
        test_pack();
        test_ramp();
        test_backpressure();
        test_canonical();
        test_control();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
        $fatal(1);
    end
endmodule
